mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Shares one Avalon-style port of the four-port LPDDR2 RAM interface among three requesters.
- The requesters are: camera 1 capture writer, camera 2 capture writer, and the HDMI frame reader.
- Serialises single-word write and read commands onto the port and routes returned read data back to the reader.
- Bounds the number of reads in flight.
- Sits between the capture/frame-buffer logic and the RAM interface port, in the 25.2 MHz pixel-clock domain.

Parameters:
ADDR_W, 29, Avalon word-address width
DATA_W, 32, data width
MAX_RD_OUT, 4, maximum reads issued but not yet returned (1..15)
STARVE_LIMIT, 64, wait-cycle threshold for the optional starvation guard

Ports:
clk  in  1  pixel clock; all logic rising-edge
reset  in  1  synchronous reset, active-high
ram_rdy  in  1  RAM calibration done; no new grants while low
c1_req  in  1  camera 1 write request; held until c1_ack
c1_addr  in  ADDR_W  camera 1 write address
c1_wdata  in  DATA_W  camera 1 write data
c1_ack  out  1  one-cycle pulse: camera 1 command accepted by RAM
c2_req / c2_addr / c2_wdata / c2_ack  same as camera 1, for camera 2
rd_req  in  1  reader request; held until rd_ack
rd_addr  in  ADDR_W  read address
rd_ack  out  1  one-cycle pulse: read command accepted
rd_data  out  DATA_W  returned read data
rd_valid  out  1  rd_data valid this cycle
avl_ready  in  1  RAM port accepts command this cycle
avl_write_req  out  1  write command
avl_read_req  out  1  read command
avl_addr  out  ADDR_W  command address
avl_wdata  out  DATA_W  write data
avl_rd_data  in  DATA_W  read data from RAM
avl_rd_data_valid  in  1  read data valid
rd_outstanding  out  4  current in-flight read count
busy  out  1  high in ISSUE
err_spurious  out  1  sticky: read data returned with zero outstanding

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; rd_outstanding 0; round-robin pointer to camera 1.
  - Reset is a synchronous override from any state: an in-flight command is abandoned and avl_*_req drop at the next edge.
- States:
  - IDLE:
    - If ram_rdy=1 and any eligible request exists, select a winner.
    - Register its addr/wdata/type into avl_* and go to ISSUE. avl_*_req rises in the cycle after req is sampled.
  - ISSUE:
    - Hold avl_write_req or avl_read_req (exactly one high), plus avl_addr and avl_wdata, stable.
    - On the edge where avl_ready=1: pulse the winner's ack for one cycle, drop avl_*_req, return to IDLE.
    - Minimum cost is 2 cycles per command; back-to-back commands therefore issue every 2 cycles.
    - ram_rdy falling during ISSUE does not abort the command.
- Eligibility:
  - Reader is eligible iff rd_req=1 and rd_outstanding < MAX_RD_OUT.
  - Cameras are eligible iff their req=1.
- Priority:
  - Eligible reader wins over both cameras, so display has priority.
  - Between cameras, round-robin: the pointer moves to the other camera after each camera grant. A lone requesting camera always wins.
- Outstanding counter:
  - +1 on read command acceptance; -1 on avl_rd_data_valid.
  - Both in the same cycle: unchanged.
  - avl_rd_data_valid while count is 0: count stays 0 and err_spurious sets, cleared only by reset.
- Read return path: rd_data/rd_valid are avl_rd_data/avl_rd_data_valid registered once, so latency is 1 cycle, with order preserved.
- Requesters must not change addr/wdata while req is high and not acked. A req dropped before ack is a protocol violation and is not checked; the registered command still completes.
- The ack goes only to the winner; the other requesters see no ack.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN:
- Defined:
  - Per-camera 8-bit wait counter.
  - Increments each cycle the camera's req=1 without its ack; clears on ack or when req=0.
  - Saturates at 255.
  - A camera whose counter >= STARVE_LIMIT outranks the reader at the next IDLE selection. If both cameras qualify, the round-robin pointer breaks the tie.
- Undefined: the counters are absent and the reader always has priority.

Decomposition:
- Shared package mem_arb_pkg:
  - State enum {IDLE, ISSUE}.
  - Requester ID constants REQ_C1=0, REQ_C2=1, REQ_RD=2.
  - Default ADDR_W/DATA_W.
- One natural sub-module, mem_arb_sel: combinational winner select from eligibility, the round-robin pointer, and the optional starve flags. Outputs a one-hot grant.

Test Plan:
1. c1_req only, c1_addr=0x100, c1_wdata=0xFFFFFF, avl_ready tied 1 -> avl_write_req high 1 cycle with addr 0x100; c1_ack pulse 2 cycles after req.
2. c1_req and c2_req held for 8 commands -> grant order C1,C2,C1,C2,...; 4 acks each.
3. rd_req held, avl_rd_data_valid never asserted, MAX_RD_OUT=4 -> exactly 4 rd_ack, rd_outstanding=4, then avl_read_req stays low. One avl_rd_data_valid with data 0xA5A5A5A5 -> rd_valid/rd_data=0xA5A5A5A5 one cycle later and a 5th read issues.
4. avl_ready held 0 for 10 cycles in ISSUE -> avl_write_req, addr, and data stable for all 10 cycles; ack only after avl_ready=1.
5. reset asserted mid-ISSUE -> next cycle avl_*_req=0, rd_outstanding=0, no ack. With ram_rdy=0 and requests pending -> no command issues.
6. With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT=8, rd_req and c1_req both held -> c1 granted once its wait count reaches 8. Without the macro, c1 is not granted until rd_outstanding reaches MAX_RD_OUT. avl_rd_data_valid at count 0 -> err_spurious=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-requester RAM port arbiter.
// Requester IDs index the one-hot grant/ack vectors used across the slice.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 29;
    localparam int DATA_W_DEF = 32;

    localparam int N_REQ  = 3;
    localparam int REQ_C1 = 0;
    localparam int REQ_C2 = 1;
    localparam int REQ_RD = 2;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_e;

    // Camera round-robin: returns 1 when camera 2 should win.
    // A lone camera always wins; with both, the pointer decides.
    function automatic logic pick_c2(
        input logic c1,
        input logic c2,
        input logic rr_c2
    );
        return c2 & (~c1 | rr_c2);
    endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Requester, RAM-port and status bundle of the memory port arbiter.
// master: arbiter side; slave: requesters + RAM port + observers.
interface mem_port_arb_if #(
    parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
    parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
);

    logic              ram_rdy;

    logic              c1_req;
    logic [ADDR_W-1:0] c1_addr;
    logic [DATA_W-1:0] c1_wdata;
    logic              c1_ack;

    logic              c2_req;
    logic [ADDR_W-1:0] c2_addr;
    logic [DATA_W-1:0] c2_wdata;
    logic              c2_ack;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    logic              avl_ready;
    logic              avl_write_req;
    logic              avl_read_req;
    logic [ADDR_W-1:0] avl_addr;
    logic [DATA_W-1:0] avl_wdata;
    logic [DATA_W-1:0] avl_rd_data;
    logic              avl_rd_data_valid;

    logic [3:0]        rd_outstanding;
    logic              busy;
    logic              err_spurious;

    modport master (
        input  ram_rdy,
        input  c1_req, c1_addr, c1_wdata,
        output c1_ack,
        input  c2_req, c2_addr, c2_wdata,
        output c2_ack,
        input  rd_req, rd_addr,
        output rd_ack, rd_data, rd_valid,
        input  avl_ready, avl_rd_data, avl_rd_data_valid,
        output avl_write_req, avl_read_req, avl_addr, avl_wdata,
        output rd_outstanding, busy, err_spurious
    );

    modport slave (
        output ram_rdy,
        output c1_req, c1_addr, c1_wdata,
        input  c1_ack,
        output c2_req, c2_addr, c2_wdata,
        input  c2_ack,
        output rd_req, rd_addr,
        input  rd_ack, rd_data, rd_valid,
        output avl_ready, avl_rd_data, avl_rd_data_valid,
        input  avl_write_req, avl_read_req, avl_addr, avl_wdata,
        input  rd_outstanding, busy, err_spurious
    );

endinterface

// File: rtl/mem_arb_sel.sv
// Combinational winner select: starving cameras, then reader, then cameras.
// Ports: *_elig_i eligibility, rr_c2_i pointer, starve_i flags, gnt_o one-hot.
module mem_arb_sel
    import mem_arb_pkg::*;
(
    input  logic             c1_elig_i,
    input  logic             c2_elig_i,
    input  logic             rd_elig_i,
    input  logic             rr_c2_i,
    input  logic [1:0]       starve_i,
    output logic [N_REQ-1:0] gnt_o
);

    logic s1;
    logic s2;

    assign s1 = c1_elig_i & starve_i[0];
    assign s2 = c2_elig_i & starve_i[1];

    always_comb begin
        gnt_o = '0;
        if (s1 | s2) begin
            if (pick_c2(s1, s2, rr_c2_i)) gnt_o[REQ_C2] = 1'b1;
            else                          gnt_o[REQ_C1] = 1'b1;
        end else if (rd_elig_i) begin
            gnt_o[REQ_RD] = 1'b1;
        end else if (c1_elig_i | c2_elig_i) begin
            if (pick_c2(c1_elig_i, c2_elig_i, rr_c2_i)) gnt_o[REQ_C2] = 1'b1;
            else                                        gnt_o[REQ_C1] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Shares one Avalon RAM port among camera 1/2 writers and the HDMI reader.
// Ports: clk, reset (sync, active-high), bus (mem_port_arb_if.master).
// Optional: MEM_ARB_STARVE_GUARD_EN lets long-waiting cameras beat the reader.
module mem_port_arb
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_RD_OUT   = 4,
    parameter int STARVE_LIMIT = 64
) (
    input  logic           clk,
    input  logic           reset,
    mem_port_arb_if.master bus
);

    if (MAX_RD_OUT < 1 || MAX_RD_OUT > 15 ||
        STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
        $error("mem_port_arb: parameter out of range");
    end

    state_e             state_q, state_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [N_REQ-1:0]   own_q, own_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               rr_q, rr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rdat_q;
    logic               rval_q;

    logic               rd_elig;
    logic [1:0]         starve;
    logic [N_REQ-1:0]   gnt;
    logic               rd_acc;

    assign rd_elig = bus.rd_req & (cnt_q < 4'(MAX_RD_OUT));

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [7:0] w1_q, w1_d;
    logic [7:0] w2_q, w2_d;

    // Counts cycles a camera has been waiting; any ack or idle req clears.
    always_comb begin
        w1_d = w1_q;
        w2_d = w2_q;
        if (!bus.c1_req || ack_q[REQ_C1]) w1_d = '0;
        else if (w1_q != 8'hFF)            w1_d = w1_q + 8'd1;
        if (!bus.c2_req || ack_q[REQ_C2]) w2_d = '0;
        else if (w2_q != 8'hFF)            w2_d = w2_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w1_q <= '0;
            w2_q <= '0;
        end else begin
            w1_q <= w1_d;
            w2_q <= w2_d;
        end
    end

    assign starve = {32'(w2_q) >= STARVE_LIMIT, 32'(w1_q) >= STARVE_LIMIT};
`else
    assign starve = 2'b00;
`endif

    mem_arb_sel u_sel (
        .c1_elig_i (bus.c1_req),
        .c2_elig_i (bus.c2_req),
        .rd_elig_i (rd_elig),
        .rr_c2_i   (rr_q),
        .starve_i  (starve),
        .gnt_o     (gnt)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        own_d   = own_q;
        rr_d    = rr_q;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.ram_rdy && (|gnt)) begin
                    state_d = ISSUE;
                    own_d   = gnt;
                    wr_d    = ~gnt[REQ_RD];
                    rd_d    = gnt[REQ_RD];
                    unique case (1'b1)
                        gnt[REQ_RD]: begin
                            addr_d  = bus.rd_addr;
                            wdata_d = '0;
                        end
                        gnt[REQ_C2]: begin
                            addr_d  = bus.c2_addr;
                            wdata_d = bus.c2_wdata;
                            rr_d    = 1'b0;
                        end
                        default: begin
                            addr_d  = bus.c1_addr;
                            wdata_d = bus.c1_wdata;
                            rr_d    = 1'b1;
                        end
                    endcase
                end
            end
            ISSUE: begin
                // ram_rdy is ignored here: an issued command always completes.
                if (bus.avl_ready) begin
                    state_d = IDLE;
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    ack_d   = own_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_acc = (state_q == ISSUE) & rd_q & bus.avl_ready;

    // Simultaneous accept and return cancel; a return at zero is spurious.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        unique case ({rd_acc, bus.avl_rd_data_valid})
            2'b10: cnt_d = cnt_q + 4'd1;
            2'b01: begin
                if (cnt_q == 4'd0) err_d = 1'b1;
                else               cnt_d = cnt_q - 4'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            own_q   <= '0;
            ack_q   <= '0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
            rval_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            own_q   <= own_d;
            ack_q   <= ack_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdat_q  <= bus.avl_rd_data;
            rval_q  <= bus.avl_rd_data_valid;
        end
    end

    assign bus.c1_ack         = ack_q[REQ_C1];
    assign bus.c2_ack         = ack_q[REQ_C2];
    assign bus.rd_ack         = ack_q[REQ_RD];
    assign bus.avl_write_req  = wr_q;
    assign bus.avl_read_req   = rd_q;
    assign bus.avl_addr       = addr_q;
    assign bus.avl_wdata      = wdata_q;
    assign bus.rd_data        = rdat_q;
    assign bus.rd_valid       = rval_q;
    assign bus.rd_outstanding = cnt_q;
    assign bus.busy           = (state_q == ISSUE);
    assign bus.err_spurious   = err_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed and randomized checks for mem_port_arb against rule-level model.
// Covers grants, priority, round-robin, read window, returns and reset.
module tb_mem_port_arb;
    import mem_arb_pkg::*;

    localparam int AW   = 29;
    localparam int DW   = 32;
    localparam int MAXR = 4;
    localparam int SLIM = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arb #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_RD_OUT(MAXR), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ram_rdy = 1'b1;
        bus.c1_req = 1'b0; bus.c1_addr = '0; bus.c1_wdata = '0;
        bus.c2_req = 1'b0; bus.c2_addr = '0; bus.c2_wdata = '0;
        bus.rd_req = 1'b0; bus.rd_addr = '0;
        bus.avl_ready = 1'b1;
        bus.avl_rd_data = '0;
        bus.avl_rd_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // random-phase model state
    logic          r_act [3];
    logic [AW-1:0] r_addr [3];
    logic [DW-1:0] r_data [3];

    initial begin : main
        int n1, n2, ncmd, nack, grant_edge, cnt_at;
        logic [AW-1:0] got [$];
        logic p_cmd, p_rd, p_ready, p_vld, p_any;
        logic p_e_rd, p_e_c1, p_e_c2, gen;
        logic [AW-1:0] p_addr;
        logic [DW-1:0] p_wdata, p_vdata;
        int p_owner, owner, cnt, last_cam, ok;
        logic [2:0] a;
        logic cur;

        // reset state
        do_reset();
        chk("rst_wr", bus.avl_write_req, 0);
        chk("rst_rd", bus.avl_read_req, 0);
        chk("rst_acks", {bus.c1_ack, bus.c2_ack, bus.rd_ack}, 0);
        chk("rst_cnt", bus.rd_outstanding, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err", bus.err_spurious, 0);
        chk("rst_rval", bus.rd_valid, 0);

        // 1: single camera write
        bus.c1_req = 1; bus.c1_addr = 29'h100; bus.c1_wdata = 32'hFFFFFF;
        cyc();
        chk("t1_wr", bus.avl_write_req, 1);
        chk("t1_addr", bus.avl_addr, 29'h100);
        chk("t1_wdata", bus.avl_wdata, 32'hFFFFFF);
        chk("t1_noack", bus.c1_ack, 0);
        cyc();
        chk("t1_ack", bus.c1_ack, 1);
        chk("t1_wr_drop", bus.avl_write_req, 0);
        bus.c1_req = 0;
        cyc();
        chk("t1_ack_pulse", bus.c1_ack, 0);
        chk("t1_wr_idle", bus.avl_write_req, 0);

        // 2: round-robin between cameras
        do_reset();
        bus.c1_req = 1; bus.c1_addr = 29'h200; bus.c1_wdata = 32'h1;
        bus.c2_req = 1; bus.c2_addr = 29'h300; bus.c2_wdata = 32'h2;
        n1 = 0; n2 = 0; ncmd = 0;
        for (int i = 0; i < 40 && !(ncmd == 8 && n1 + n2 == 8); i++) begin
            cyc();
            if (bus.c1_ack) begin n1++; bus.c1_addr++; end
            if (bus.c2_ack) begin n2++; bus.c2_addr++; end
            if (bus.avl_write_req) begin
                got.push_back(bus.avl_addr);
                ncmd++;
                if (ncmd == 8) begin bus.c1_req = 0; bus.c2_req = 0; end
            end
        end
        chk("t2_ncmd", got.size(), 8);
        chk("t2_c1_acks", n1, 4);
        chk("t2_c2_acks", n2, 4);
        for (int k = 0; k < got.size(); k++)
            chk($sformatf("t2_order%0d", k), got[k],
                ((k % 2) == 0 ? 29'h200 : 29'h300) + 29'(k / 2));

        // 3: read window limit and return path
        do_reset();
        bus.rd_req = 1; bus.rd_addr = 29'h40;
        nack = 0;
        repeat (20) begin
            cyc();
            if (bus.rd_ack) nack++;
        end
        chk("t3_acks", nack, MAXR);
        chk("t3_cnt", bus.rd_outstanding, MAXR);
        chk("t3_blocked", bus.avl_read_req, 0);
        bus.avl_rd_data_valid = 1; bus.avl_rd_data = 32'hA5A5A5A5;
        cyc();
        bus.avl_rd_data_valid = 0;
        chk("t3_rval", bus.rd_valid, 1);
        chk("t3_rdata", bus.rd_data, 32'hA5A5A5A5);
        chk("t3_cnt_dec", bus.rd_outstanding, MAXR - 1);
        cyc();
        chk("t3_5th_rd", bus.avl_read_req, 1);
        chk("t3_rval_pulse", bus.rd_valid, 0);
        cyc();
        chk("t3_5th_ack", bus.rd_ack, 1);
        chk("t3_cnt_full", bus.rd_outstanding, MAXR);
        bus.rd_req = 0;
        bus.avl_rd_data_valid = 1;
        repeat (MAXR) cyc();
        bus.avl_rd_data_valid = 0;
        chk("t3_drain", bus.rd_outstanding, 0);
        chk("t3_no_err", bus.err_spurious, 0);

        // 4: stall with avl_ready low
        do_reset();
        bus.avl_ready = 0;
        bus.c2_req = 1; bus.c2_addr = 29'h555; bus.c2_wdata = 32'hDEADBEEF;
        cyc();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t4_wr%0d", i), bus.avl_write_req, 1);
            chk($sformatf("t4_addr%0d", i), bus.avl_addr, 29'h555);
            chk($sformatf("t4_wd%0d", i), bus.avl_wdata, 32'hDEADBEEF);
            chk($sformatf("t4_noack%0d", i), bus.c2_ack, 0);
            cyc();
        end
        bus.avl_ready = 1;
        cyc();
        chk("t4_ack", bus.c2_ack, 1);
        chk("t4_other_acks", {bus.c1_ack, bus.rd_ack}, 0);
        chk("t4_wr_drop", bus.avl_write_req, 0);
        bus.c2_req = 0;

        // 5: reset mid-ISSUE, then ram_rdy gating and reader priority
        do_reset();
        bus.rd_req = 1; bus.rd_addr = 29'h80;
        cyc();
        cyc();
        bus.rd_req = 0;
        chk("t5_cnt1", bus.rd_outstanding, 1);
        bus.avl_ready = 0;
        bus.c1_req = 1; bus.c1_addr = 29'h123; bus.c1_wdata = 32'h77;
        cyc();
        chk("t5_issue", bus.avl_write_req, 1);
        reset = 1;
        cyc();
        chk("t5_rst_wr", bus.avl_write_req, 0);
        chk("t5_rst_rd", bus.avl_read_req, 0);
        chk("t5_rst_cnt", bus.rd_outstanding, 0);
        chk("t5_rst_ack", bus.c1_ack, 0);
        chk("t5_rst_busy", bus.busy, 0);
        reset = 0;
        bus.ram_rdy = 0; bus.avl_ready = 1; bus.rd_req = 1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk($sformatf("t5_gated%0d", i), bus.busy, 0);
        end
        bus.ram_rdy = 1;
        cyc();
        chk("t5_rd_first", bus.avl_read_req, 1);
        chk("t5_rd_first_wr", bus.avl_write_req, 0);
        cyc();
        chk("t5_rd_ack", bus.rd_ack, 1);
        bus.rd_req = 0;
        cyc();
        chk("t5_cam_next", bus.avl_write_req, 1);
        cyc();
        chk("t5_cam_ack", bus.c1_ack, 1);
        bus.c1_req = 0;
        bus.avl_rd_data_valid = 1;
        cyc();
        bus.avl_rd_data_valid = 0;
        chk("t5_drain", bus.rd_outstanding, 0);

        // 6a: reader saturates window, then camera gets in
        do_reset();
        bus.rd_req = 1; bus.rd_addr = 29'h60;
        bus.c1_req = 1; bus.c1_addr = 29'h777; bus.c1_wdata = 32'h5;
        cnt_at = -1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (bus.avl_write_req && cnt_at < 0) cnt_at = bus.rd_outstanding;
            if (bus.c1_ack) bus.c1_req = 0;
        end
        chk("t6_cnt_at_cam_grant", cnt_at, MAXR);

        // 6b: reader never saturates; only the starve guard lets c1 in
        do_reset();
        bus.rd_req = 1; bus.rd_addr = 29'h60;
        bus.c1_req = 1; bus.c1_addr = 29'h777; bus.c1_wdata = 32'h5;
        grant_edge = -1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (bus.avl_write_req && grant_edge < 0) grant_edge = i + 1;
            if (bus.c1_ack) bus.c1_req = 0;
            bus.avl_rd_data_valid = (bus.rd_outstanding != 0);
            bus.avl_rd_data = $urandom;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk("t6_starve_grant_edge", grant_edge, SLIM + 1);
`else
        chk("t6_no_cam_grant", grant_edge, -1);
`endif

        // spurious return
        do_reset();
        bus.avl_rd_data_valid = 1; bus.avl_rd_data = 32'h1234;
        cyc();
        bus.avl_rd_data_valid = 0;
        chk("sp_err", bus.err_spurious, 1);
        chk("sp_cnt", bus.rd_outstanding, 0);
        cyc();
        chk("sp_sticky", bus.err_spurious, 1);

        // randomized traffic against the rule-level model
        do_reset();
        for (int k = 0; k < 3; k++) begin
            r_act[k] = 0; r_addr[k] = '0; r_data[k] = '0;
        end
        p_cmd = 0; p_rd = 0; p_ready = 0; p_vld = 0; p_any = 0;
        p_e_rd = 0; p_e_c1 = 0; p_e_c2 = 0;
        p_addr = '0; p_wdata = '0; p_vdata = '0; p_owner = 0;
        cnt = 0; last_cam = REQ_C2; gen = 1;
        for (int t = 0; t < 1400; t++) begin
            if (t == 900) gen = 0;
            if (!gen && !r_act[0] && !r_act[1] && !r_act[2] &&
                cnt == 0 && !p_cmd) break;
            cyc();
            a = {bus.rd_ack, bus.c2_ack, bus.c1_ack};
            for (int k = 0; k < 3; k++)
                chk($sformatf("r_ack%0d", k), a[k],
                    p_cmd && p_ready && p_owner == k);
            cur = bus.avl_write_req | bus.avl_read_req;
            chk("r_onehot", bus.avl_write_req & bus.avl_read_req, 0);
            chk("r_busy", bus.busy, cur);
            if (p_cmd && !p_ready) begin
                chk("r_hold_req", {bus.avl_write_req, bus.avl_read_req},
                    {~p_rd, p_rd});
                chk("r_hold_addr", bus.avl_addr, p_addr);
                chk("r_hold_wd", bus.avl_wdata, p_wdata);
            end
            cnt = cnt + ((p_cmd && p_rd && p_ready) ? 1 : 0) - (p_vld ? 1 : 0);
            chk("r_cnt", bus.rd_outstanding, cnt);
            chk("r_cnt_max", bus.rd_outstanding <= MAXR, 1);
            chk("r_rval", bus.rd_valid, p_vld);
            if (p_vld) chk("r_rdata", bus.rd_data, p_vdata);
            owner = 0;
            if (cur) begin
                if (bus.avl_read_req)                owner = REQ_RD;
                else if (bus.avl_addr[28:27] == 2'b10) owner = REQ_C2;
                else                                 owner = REQ_C1;
                chk("r_owner_req", r_act[owner], 1);
                chk("r_cmd_addr", bus.avl_addr, r_addr[owner]);
                if (owner != REQ_RD)
                    chk("r_cmd_wd", bus.avl_wdata, r_data[owner]);
            end
            if (!p_cmd) begin
                chk("r_grant_taken", cur, p_any);
`ifndef MEM_ARB_STARVE_GUARD_EN
                if (cur && p_e_rd) chk("r_rd_prio", owner, REQ_RD);
                if (cur && !p_e_rd && p_e_c1 && p_e_c2)
                    chk("r_rr", owner, last_cam == REQ_C1 ? REQ_C2 : REQ_C1);
`endif
                if (cur && owner != REQ_RD) last_cam = owner;
            end
            for (int k = 0; k < 3; k++) begin
                if (a[k]) r_act[k] = 0;
                if (gen && !r_act[k] && $urandom_range(0, 2) == 0) begin
                    r_act[k] = 1;
                    r_addr[k] = {(k == 0 ? 2'b01 : k == 1 ? 2'b10 : 2'b11),
                                 27'($urandom)};
                    r_data[k] = $urandom;
                end
            end
            bus.c1_req = r_act[0]; bus.c1_addr = r_addr[0];
            bus.c1_wdata = r_data[0];
            bus.c2_req = r_act[1]; bus.c2_addr = r_addr[1];
            bus.c2_wdata = r_data[1];
            bus.rd_req = r_act[2]; bus.rd_addr = r_addr[2];
            bus.avl_ready = 1'($urandom_range(0, 1));
            bus.avl_rd_data_valid = (cnt > 0) && ($urandom_range(0, 2) == 0);
            bus.avl_rd_data = $urandom;
            p_e_rd = r_act[2] && (cnt < MAXR);
            p_e_c1 = r_act[0];
            p_e_c2 = r_act[1];
            p_any = p_e_rd | p_e_c1 | p_e_c2;
            p_cmd = cur; p_rd = bus.avl_read_req;
            p_addr = bus.avl_addr; p_wdata = bus.avl_wdata;
            p_owner = owner; p_ready = bus.avl_ready;
            p_vld = bus.avl_rd_data_valid; p_vdata = bus.avl_rd_data;
        end
        ok = (!r_act[0] && !r_act[1] && !r_act[2] && cnt == 0) ? 1 : 0;
        chk("r_drained", ok, 1);
        chk("r_no_err", bus.err_spurious, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
